dat_write_feeder: RTL

- Upstream stage of the SD DAT-line block writer.
- Buffers 32-bit words written by the host through the Buffer Data Port into a word FIFO.
- Sequences single- and multi-block write transfers: starts the writer only once a complete block is buffered, supplies words on each `next_word` request, and collects per-block completion and error status.
- Sits between the SDHCI register file and the DAT write engine.

---
 rtl/sdhci_pkg.sv | 19 +
 rtl/sync_word_fifo.sv | 46 ++++
 rtl/dat_write_feeder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/sdhci_pkg.sv
// Shared types and helpers for the SDHCI DAT-line write path.
package sdhci_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_DATA,
    START,
    SEND,
    CHECK
  } feeder_state_e;

  // 32-bit words needed to carry a block; the last word may be partially used.
  function automatic logic [15:0] words_per_block(input logic [15:0] bytes);
    logic [17:0] sum;
    sum = {2'b00, bytes} + 18'd3;
    return sum[17:2];
  endfunction

endpackage

// File: rtl/sync_word_fifo.sv
// Single-clock word FIFO with extra-bit pointers, flush and fill count.
module sync_word_fifo #(
  parameter  int Depth = 256,
  parameter  int Width = 32,
  localparam int AW    = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] din_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [Width-1:0] dout_o,
  output logic [AW:0]      fill_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [Width-1:0] mem [Depth];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             push_ok, pop_ok;

  assign fill_o  = wr_ptr_q - rd_ptr_q;
  assign full_o  = (fill_o == (AW+1)'(Depth));
  assign empty_o = (fill_o == '0);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign dout_o  = empty_o ? '0 : mem[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr_q[AW-1:0]] <= din_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      // A word pushed in the flush cycle lands at the old write pointer and survives.
      if (flush_i)     rd_ptr_q <= wr_ptr_q;
      else if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/dat_write_feeder.sv
// Buffers host write words and sequences block-by-block hand-off to the DAT write engine.
module dat_write_feeder
  import sdhci_pkg::*;
#(
  parameter int MaxBlockBitSize = 12,
  parameter int FifoDepthWords  = 256
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       wr_valid_i,
  input  logic [31:0]                wr_data_i,
  output logic                       wr_ready_o,
  input  logic                       xfer_start_i,
  input  logic                       abort_i,
  input  logic [MaxBlockBitSize-1:0] block_size_i,
  input  logic [15:0]                block_count_i,
  input  logic                       multi_block_i,
  output logic                       dw_start_o,
  output logic [31:0]                dw_data_o,
  input  logic                       dw_next_word_i,
  input  logic                       dw_done_i,
  input  logic                       dw_crc_err_i,
  input  logic                       dw_end_bit_err_i,
  output logic                       buf_write_ready_o,
  output logic                       block_done_o,
  output logic                       xfer_complete_o,
  output logic                       crc_err_o,
  output logic                       end_bit_err_o,
  output logic                       underrun_o,
  output logic                       overrun_o,
  output logic                       busy_o,
  output logic [15:0]                blocks_left_o
);

  localparam int AW   = $clog2(FifoDepthWords);
  localparam int WpbW = MaxBlockBitSize - 1;

  feeder_state_e   state_q, state_d;
  logic [WpbW-1:0] wpb;
  logic [15:0]     wpb_w, fill_w, free_w, start_blocks, blocks_left_q, word_cnt_q;
  logic [AW:0]     fill;
  logic            fifo_full, fifo_empty, pop_req, start_acc;
  logic            crc_q, end_q, blk_err_q;

  assign wpb          = WpbW'(words_per_block(16'(block_size_i)));
  assign wpb_w        = 16'(wpb);
  assign fill_w       = 16'(fill);
  assign free_w       = 16'(FifoDepthWords) - fill_w;
  assign start_blocks = multi_block_i ? block_count_i : 16'd1;
  assign start_acc    = xfer_start_i && !abort_i && (state_q == IDLE);
  assign pop_req      = dw_next_word_i && (state_q != IDLE);
  assign blk_err_q    = crc_q | end_q;

  assign wr_ready_o    = !fifo_full;
  assign busy_o        = (state_q != IDLE);
  assign dw_start_o    = (state_q == START);
  assign blocks_left_o = blocks_left_q;

  sync_word_fifo #(
    .Depth (FifoDepthWords),
    .Width (32)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (wr_valid_i),
    .din_i   (wr_data_i),
    .pop_i   (pop_req),
    .flush_i (abort_i),
    .dout_o  (dw_data_o),
    .fill_o  (fill),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (xfer_start_i && start_blocks != '0) state_d = WAIT_DATA;
      WAIT_DATA: if (fill_w >= wpb_w) state_d = START;
      // The writer only samples start while idle, so holding it until the first pop is safe.
      START:     if (dw_next_word_i) state_d = SEND;
      SEND:      if (dw_done_i) state_d = CHECK;
      CHECK:     state_d = (blk_err_q || blocks_left_q == 16'd1) ? IDLE : WAIT_DATA;
      default:   state_d = IDLE;
    endcase
    if (abort_i) state_d = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      blocks_left_q     <= '0;
      word_cnt_q        <= '0;
      crc_q             <= 1'b0;
      end_q             <= 1'b0;
      crc_err_o         <= 1'b0;
      end_bit_err_o     <= 1'b0;
      underrun_o        <= 1'b0;
      overrun_o         <= 1'b0;
      block_done_o      <= 1'b0;
      xfer_complete_o   <= 1'b0;
      buf_write_ready_o <= 1'b1;
    end else begin
      block_done_o      <= 1'b0;
      xfer_complete_o   <= 1'b0;
      buf_write_ready_o <= (free_w >= wpb_w);

      if (abort_i) begin
        blocks_left_q <= '0;
      end else if (start_acc) begin
        blocks_left_q   <= start_blocks;
        xfer_complete_o <= (start_blocks == '0);
        crc_err_o       <= 1'b0;
        end_bit_err_o   <= 1'b0;
        underrun_o      <= 1'b0;
        overrun_o       <= 1'b0;
      end else if (state_q == CHECK) begin
        if (blk_err_q) begin
          crc_err_o     <= crc_err_o | crc_q;
          end_bit_err_o <= end_bit_err_o | end_q;
        end else begin
          block_done_o    <= 1'b1;
          blocks_left_q   <= blocks_left_q - 16'd1;
          xfer_complete_o <= (blocks_left_q == 16'd1);
        end
      end

      // word_cnt_q counts pops of the current block; the START pop is word 0.
      if (state_q == START && dw_next_word_i)
        word_cnt_q <= 16'd1;
      else if (state_q == SEND && dw_next_word_i && word_cnt_q != '1)
        word_cnt_q <= word_cnt_q + 16'd1;

      if (state_q == SEND && dw_done_i) begin
        crc_q <= dw_crc_err_i;
        end_q <= dw_end_bit_err_i;
      end

      if ((pop_req && fifo_empty) || (state_q == SEND && dw_next_word_i && word_cnt_q >= wpb_w))
        underrun_o <= 1'b1;
      if (wr_valid_i && fifo_full)
        overrun_o <= 1'b1;
    end
  end

endmodule
